// File: rtl/wasca_abus_pkg.sv
// Shared types and helpers for the A-bus to on-chip RAM bridge.
package wasca_abus_pkg;

    localparam int ABUS_ADDR_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_CAP,
        ST_ACK
    } abus_state_t;

    // Big-endian halfword placement: the even half lives in the upper RAM lanes.
    function automatic logic [3:0] be_map(input logic addr1, input logic [1:0] be);
        return addr1 ? {2'b00, be} : {be, 2'b00};
    endfunction

endpackage

// File: rtl/wasca_abus_word_latch.sv
// One-word read latch: captures a RAM word, merges write bytes when the tag matches,
// and serves either halfword on a lookup hit.
module wasca_abus_word_latch
    import wasca_abus_pkg::*;
#(
    parameter int ADDR_W = ABUS_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cap_en,
    input  logic [ADDR_W-1:0] cap_tag,
    input  logic [31:0]       cap_data,
    input  logic              merge_en,
    input  logic [ADDR_W-1:0] merge_tag,
    input  logic [3:0]        merge_be,
    input  logic [31:0]       merge_data,
    input  logic [ADDR_W-1:0] look_tag,
    input  logic              look_half,
    output logic              hit,
    output logic [15:0]       look_data
);

    logic [31:0]       data_q;
    logic [ADDR_W-1:0] tag_q;
    logic              valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else if (cap_en) begin
            data_q  <= cap_data;
            tag_q   <= cap_tag;
            valid_q <= 1'b1;
        end else if (merge_en && valid_q && (tag_q == merge_tag)) begin
            for (int i = 0; i < 4; i++) begin
                if (merge_be[i]) data_q[8*i +: 8] <= merge_data[8*i +: 8];
            end
        end
    end

    assign hit       = valid_q && (tag_q == look_tag);
    assign look_data = look_half ? data_q[15:0] : data_q[31:16];

endmodule

// File: rtl/wasca_abus_mem_bridge.sv
// A-bus 16-bit halfword requests to 32-bit Avalon RAM cycles, with an optional
// one-word read latch so the second half of a word is served without a RAM cycle.
module wasca_abus_mem_bridge
    import wasca_abus_pkg::*;
#(
    parameter int ADDR_W      = ABUS_ADDR_W,
    parameter int HOST_AW     = ADDR_W + 2,
    parameter bit PREFETCH_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               host_req,
    input  logic               host_wr,
    input  logic [HOST_AW-1:0] host_addr,
    input  logic [1:0]         host_be,
    input  logic [15:0]        host_wdata,
    output logic               host_ack,
    output logic [15:0]        host_rdata,
    output logic               host_busy,
    output logic               err_overrun,
    input  logic               err_clr,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [3:0]         mem_byteen,
    output logic               mem_cs,
    output logic               mem_write,
    output logic [31:0]        mem_wdata,
    output logic               mem_clken,
    input  logic [31:0]        mem_rdata
);

    abus_state_t       state;
    logic              req_wr;
    logic              req_half;
    logic [15:0]       rd_hold;
    logic [ADDR_W-1:0] host_word;
    logic              lat_hit;
    logic [15:0]       lat_data;
    logic              unused_addr0;

    assign host_word    = host_addr[HOST_AW-1:2];
    assign unused_addr0 = host_addr[0];

    generate
        if (PREFETCH_EN) begin : g_latch
            wasca_abus_word_latch #(.ADDR_W(ADDR_W)) u_latch (
                .clk        (clk),
                .reset_n    (reset_n),
                .cap_en     (state == ST_CAP),
                .cap_tag    (mem_address),
                .cap_data   (mem_rdata),
                .merge_en   (state == ST_WR),
                .merge_tag  (mem_address),
                .merge_be   (mem_byteen),
                .merge_data (mem_wdata),
                .look_tag   (host_word),
                .look_half  (host_addr[1]),
                .hit        (lat_hit),
                .look_data  (lat_data)
            );
        end else begin : g_no_latch
            assign lat_hit  = 1'b0;
            assign lat_data = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            req_wr      <= 1'b0;
            req_half    <= 1'b0;
            rd_hold     <= '0;
            mem_address <= '0;
            mem_byteen  <= '0;
            mem_wdata   <= '0;
            mem_clken   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            mem_clken <= 1'b1;
            // A new overrun outranks a simultaneous clear.
            if (host_req && (state != ST_IDLE)) err_overrun <= 1'b1;
            else if (err_clr)                   err_overrun <= 1'b0;

            case (state)
                ST_IDLE: if (host_req) begin
                    req_wr   <= host_wr;
                    req_half <= host_addr[1];
                    if (host_wr) begin
                        if (host_be != 2'b00) begin
                            mem_address <= host_word;
                            mem_byteen  <= be_map(host_addr[1], host_be);
                            mem_wdata   <= {host_wdata, host_wdata};
                            state       <= ST_WR;
                        end else begin
                            state <= ST_ACK;
                        end
                    end else if (lat_hit) begin
                        rd_hold <= lat_data;
                        state   <= ST_ACK;
                    end else begin
                        mem_address <= host_word;
                        mem_byteen  <= 4'hF;
                        state       <= ST_RD;
                    end
                end
                ST_WR:   state <= ST_ACK;
                ST_RD:   state <= ST_CAP;
                ST_CAP: begin
                    rd_hold <= req_half ? mem_rdata[15:0] : mem_rdata[31:16];
                    state   <= ST_ACK;
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign host_ack   = (state == ST_ACK);
    assign host_rdata = (state == ST_ACK && !req_wr) ? rd_hold : 16'h0000;
    assign host_busy  = (state != ST_IDLE);
    assign mem_cs     = (state == ST_WR) || (state == ST_RD);
    assign mem_write  = (state == ST_WR);

endmodule

// File: tb/tb_wasca_abus_mem_bridge.sv
// Scoreboard bench: two bridges (read latch on / off) share the host bus, each backed
// by a behavioural RAM; a negedge monitor checks every ack against queued expectations.
module tb_wasca_abus_mem_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        host_req = 1'b0, host_wr = 1'b0, err_clr = 1'b0;
    logic [14:0] host_addr = '0;
    logic [1:0]  host_be = '0;
    logic [15:0] host_wdata = '0;
    logic        sel2 = 1'b0, ram_init = 1'b1;
    logic        req1, req2;

    logic        ack1, busy1, err1, cs1, wr1, clken1;
    logic [15:0] rd1;
    logic [12:0] addr1;
    logic [3:0]  be1;
    logic [31:0] wd1, rdata1;
    logic        ack2, busy2, err2, cs2, wr2, clken2;
    logic [15:0] rd2;
    logic [12:0] addr2;
    logic [3:0]  be2;
    logic [31:0] wd2, rdata2;

    logic [31:0] ram1 [0:8191];
    logic [31:0] ram2 [0:8191];

    typedef struct {
        logic [15:0] rd;
        int          lat;
        int          t;
    } exp_t;
    exp_t expq[$];

    int total = 0, bad = 0, cyc = 0, cs_cnt = 0;
    int last_cyc = 0;
    logic [12:0] last_addr = '0;
    logic [3:0]  last_be = '0;
    logic [31:0] last_wd = '0;
    logic        last_wr = 1'b0;

    assign req1 = host_req & ~sel2;
    assign req2 = host_req & sel2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wasca_abus_mem_bridge #(.PREFETCH_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .host_req(req1), .host_wr(host_wr),
        .host_addr(host_addr), .host_be(host_be), .host_wdata(host_wdata),
        .host_ack(ack1), .host_rdata(rd1), .host_busy(busy1), .err_overrun(err1),
        .err_clr(err_clr), .mem_address(addr1), .mem_byteen(be1), .mem_cs(cs1),
        .mem_write(wr1), .mem_wdata(wd1), .mem_clken(clken1), .mem_rdata(rdata1)
    );

    wasca_abus_mem_bridge #(.PREFETCH_EN(1'b0)) dut_nolatch (
        .clk(clk), .reset_n(reset_n), .host_req(req2), .host_wr(host_wr),
        .host_addr(host_addr), .host_be(host_be), .host_wdata(host_wdata),
        .host_ack(ack2), .host_rdata(rd2), .host_busy(busy2), .err_overrun(err2),
        .err_clr(err_clr), .mem_address(addr2), .mem_byteen(be2), .mem_cs(cs2),
        .mem_write(wr2), .mem_wdata(wd2), .mem_clken(clken2), .mem_rdata(rdata2)
    );

    // Behavioural RAMs: registered read, byte-enabled write.
    always @(posedge clk) begin
        if (ram_init) begin
            ram1[5] <= 32'h12345678;
            ram1[8] <= 32'hCAFEF00D;
            ram1[9] <= 32'h0BADF00D;
        end else if (cs1) begin
            if (wr1) begin
                for (int i = 0; i < 4; i++) if (be1[i]) ram1[addr1][8*i +: 8] <= wd1[8*i +: 8];
            end else begin
                rdata1 <= ram1[addr1];
            end
        end
    end

    always @(posedge clk) begin
        if (ram_init) begin
            ram2[5] <= 32'h12345678;
        end else if (cs2) begin
            if (wr2) begin
                for (int i = 0; i < 4; i++) if (be2[i]) ram2[addr2][8*i +: 8] <= wd2[8*i +: 8];
            end else begin
                rdata2 <= ram2[addr2];
            end
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: strobe snapshot and scoreboard pop on every ack.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (cs1 | cs2) begin
            cs_cnt++;
            last_cyc  = cyc;
            last_addr = addr1;
            last_be   = be1;
            last_wd   = wd1;
            last_wr   = wr1;
        end
        if (ack1 | ack2) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_ack actual=ack at cycle %0d required=no ack", cyc);
            end else begin
                e = expq.pop_front();
                chk("ack_rdata_latency", {ack2 ? rd2 : rd1, cyc - e.t}, {e.rd, e.lat});
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 12 && expq.size() != 0; i++) @(negedge clk);
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL ack_timeout actual=%0d pending required=0 pending", expq.size());
            expq.delete();
        end
    endtask

    // stray: hold host_req one extra cycle (lands while busy), optionally with err_clr.
    task automatic issue(input logic wr, input logic [14:0] addr, input logic [1:0] be,
                         input logic [15:0] wd, input logic [15:0] exp_rd, input int lat,
                         input bit stray, input bit clr, output int t);
        exp_t e;
        @(posedge clk); #1;
        host_req = 1'b1; host_wr = wr; host_addr = addr; host_be = be; host_wdata = wd;
        t = cyc;
        e.rd = exp_rd; e.lat = lat; e.t = t;
        expq.push_back(e);
        @(posedge clk); #1;
        if (stray) begin
            host_addr = addr + 15'd4;
            err_clr   = clr;
            @(posedge clk); #1;
            err_clr   = 1'b0;
        end
        host_req = 1'b0;
        wait_idle();
    endtask

    initial begin : stim
        int t, c0;
        #3000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t, c0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {ack1, rd1, busy1, err1, addr1, be1, cs1, wr1, wd1, clken1}, '0);
        ram_init = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("clken_after_reset", {clken1, clken2}, 2'b11);

        // 1: write, upper lanes
        issue(1'b1, 15'h0000, 2'b11, 16'hBEEF, 16'h0000, 2, 1'b0, 1'b0, t);
        chk("t1_strobe", {last_cyc, last_addr, last_be, last_wd, last_wr},
            {t + 1, 13'd0, 4'b1100, 32'hBEEFBEEF, 1'b1});

        // 2: miss then hit on word 5
        c0 = cs_cnt;
        issue(1'b0, 15'h0014, 2'b00, 16'h0, 16'h1234, 3, 1'b0, 1'b0, t);
        chk("t2_miss_cs", cs_cnt - c0, 1);
        c0 = cs_cnt;
        issue(1'b0, 15'h0016, 2'b00, 16'h0, 16'h5678, 1, 1'b0, 1'b0, t);
        chk("t2_hit_no_cs", cs_cnt - c0, 0);

        // 3: low-byte write into latched word keeps latch coherent
        issue(1'b1, 15'h0017, 2'b01, 16'h00AA, 16'h0000, 2, 1'b0, 1'b0, t);
        chk("t3_strobe", {last_cyc, last_addr, last_be, last_wd, last_wr},
            {t + 1, 13'd5, 4'b0001, 32'h00AA00AA, 1'b1});
        c0 = cs_cnt;
        issue(1'b0, 15'h0016, 2'b00, 16'h0, 16'h56AA, 1, 1'b0, 1'b0, t);
        chk("t3_hit_no_cs", cs_cnt - c0, 0);

        // 4: overrun during RD, then clear racing a new overrun, then plain clear
        c0 = cs_cnt;
        issue(1'b0, 15'h0020, 2'b00, 16'h0, 16'hCAFE, 3, 1'b1, 1'b0, t);
        chk("t4_one_cs", cs_cnt - c0, 1);
        chk("t4_err_set", err1, 1'b1);
        issue(1'b0, 15'h0026, 2'b00, 16'h0, 16'hF00D, 3, 1'b1, 1'b1, t);
        chk("t4_set_beats_clr", err1, 1'b1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("t4_err_cleared", err1, 1'b0);

        // 5: zero-be write, then latch-less instance always misses
        c0 = cs_cnt;
        issue(1'b1, 15'h0030, 2'b00, 16'h1111, 16'h0000, 1, 1'b0, 1'b0, t);
        chk("t5_zero_be_no_cs", cs_cnt - c0, 0);
        sel2 = 1'b1;
        c0 = cs_cnt;
        issue(1'b0, 15'h0014, 2'b00, 16'h0, 16'h1234, 3, 1'b0, 1'b0, t);
        issue(1'b0, 15'h0014, 2'b00, 16'h0, 16'h1234, 3, 1'b0, 1'b0, t);
        chk("t5_nolatch_cs", cs_cnt - c0, 2);
        sel2 = 1'b0;

        // 6: reset during CAP abandons the read and invalidates the latch
        @(posedge clk); #1;
        host_req = 1'b1; host_wr = 1'b0; host_addr = 15'h0028;
        @(posedge clk); #1;
        host_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {ack1, rd1, busy1, err1, addr1, be1, cs1, wr1, wd1, clken1}, '0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_clken", clken1, 1'b1);
        c0 = cs_cnt;
        issue(1'b0, 15'h0016, 2'b00, 16'h0, 16'h56AA, 3, 1'b0, 1'b0, t);
        chk("t6_miss_after_reset", cs_cnt - c0, 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
